// File: rtl/relobi_a_err_monitor.sv
// relOBI A-channel error monitor: counts ECC errors on accepted requests, captures the
// first uncorrectable one, raises an interrupt and optionally fences the channel.
package obi_pkg;
  typedef struct packed {
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{DataWidth: 32, IdWidth: 1};
endpackage

module relobi_a_err_monitor #(
  parameter obi_pkg::obi_cfg_t Cfg           = obi_pkg::ObiDefaultConfig,
  parameter int unsigned       CntWidth      = 16,
  parameter int unsigned       CorrThreshold = 1,
  parameter bit                BlockOnUncorr = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  output logic                         gnt_o,
  output logic                         req_o,
  input  logic                         gnt_i,
  input  logic                         we_i,
  input  logic [Cfg.DataWidth/8-1:0]   be_i,
  input  logic [Cfg.IdWidth-1:0]       aid_i,
  input  logic [1:0]                   relerr_i,
  input  logic                         clear_i,
  output logic [CntWidth-1:0]          corr_cnt_o,
  output logic [CntWidth-1:0]          uncorr_cnt_o,
  output logic                         err_valid_o,
  output logic                         err_we_o,
  output logic [Cfg.DataWidth/8-1:0]   err_be_o,
  output logic [Cfg.IdWidth-1:0]       err_aid_o,
  output logic                         fault_o,
  output logic                         irq_o
);

  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] Thr    = CntWidth'(CorrThreshold);

  typedef enum logic {ST_OK, ST_FAULT} state_e;

  state_e                       state_q, state_d;
  logic [CntWidth-1:0]          corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;
  logic                         err_valid_q, err_valid_d, err_we_q, err_we_d;
  logic [Cfg.DataWidth/8-1:0]   err_be_q, err_be_d;
  logic [Cfg.IdWidth-1:0]       err_aid_q, err_aid_d;
  logic                         irq_q, irq_d;
  logic                         hs, uncorr_ev, corr_ev;

  always_comb begin
    state_d = state_q;
    req_o   = req_i;
    gnt_o   = gnt_i;
    fault_o = 1'b0;
    if (state_q == ST_FAULT) begin
      req_o   = 1'b0;
      gnt_o   = 1'b0;
      fault_o = 1'b1;
    end

    // gnt_o is already zero in FAULT, so no event can be seen there
    hs        = req_i & gnt_o;
    uncorr_ev = hs & relerr_i[1];
    corr_ev   = hs & (relerr_i == 2'b01);

    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    err_valid_d  = err_valid_q;
    err_we_d     = err_we_q;
    err_be_d     = err_be_q;
    err_aid_d    = err_aid_q;

    if (clear_i) begin
      state_d      = ST_OK;
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
      err_valid_d  = 1'b0;
      err_we_d     = 1'b0;
      err_be_d     = '0;
      err_aid_d    = '0;
    end else begin
      if (corr_ev && corr_cnt_q != CntMax) corr_cnt_d = corr_cnt_q + CntWidth'(1);
      if (uncorr_ev) begin
        if (uncorr_cnt_q != CntMax) uncorr_cnt_d = uncorr_cnt_q + CntWidth'(1);
        if (!err_valid_q) begin
          err_valid_d = 1'b1;
          err_we_d    = we_i;
          err_be_d    = be_i;
          err_aid_d   = aid_i;
        end
        if (BlockOnUncorr) state_d = ST_FAULT;
      end
    end

    irq_d = err_valid_d | (corr_cnt_d >= Thr);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_OK;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      err_valid_q  <= 1'b0;
      err_we_q     <= 1'b0;
      err_be_q     <= '0;
      err_aid_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      err_valid_q  <= err_valid_d;
      err_we_q     <= err_we_d;
      err_be_q     <= err_be_d;
      err_aid_q    <= err_aid_d;
      irq_q        <= irq_d;
    end
  end

  assign corr_cnt_o   = corr_cnt_q;
  assign uncorr_cnt_o = uncorr_cnt_q;
  assign err_valid_o  = err_valid_q;
  assign err_we_o     = err_we_q;
  assign err_be_o     = err_be_q;
  assign err_aid_o    = err_aid_q;
  assign irq_o        = irq_q;

endmodule

// File: doc/relobi_a_err_monitor.md
# relobi_a_err_monitor

Sits directly downstream of the relOBI A-channel "other"-field ECC decoder, on the same request/grant handshake. Consumes the decoder's 2-bit error flag together with the corrected `we`/`be`/`aid` fields. Counts correctable and uncorrectable errors per accepted transaction, captures the first uncorrectable transaction, and raises an interrupt. Optionally fences the A channel after an uncorrectable error until software clears it.

## Interface
- `Cfg`, `obi_pkg::ObiDefaultConfig`: bus configuration; `DataWidth` and `IdWidth` are used.
- `CntWidth`, 16: width of both error counters.
- `CorrThreshold`, 1: `irq_o` asserts once `corr_cnt_o >= CorrThreshold`. Legal range is 1..2^CntWidth-1.
- `BlockOnUncorr`, 1'b1: 1 fences the channel after an uncorrectable error; 0 only logs it.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `req_i`  in  1  upstream request (decoded A channel).
- `gnt_o`  out  1  grant to upstream.
- `req_o`  out  1  request to downstream.
- `gnt_i`  in  1  grant from downstream.
- `we_i`  in  1  corrected write enable from the decoder.
- `be_i`  in  `Cfg.DataWidth/8`  corrected byte enables.
- `aid_i`  in  `Cfg.IdWidth`  corrected transaction ID.
- `relerr_i`  in  2  decoder error flag: bit0 = corrected single error, bit1 = uncorrectable.
- `clear_i`  in  1  synchronous clear of counters, capture and fault state.
- `corr_cnt_o`  out  `CntWidth`  saturating count of correctable errors.
- `uncorr_cnt_o`  out  `CntWidth`  saturating count of uncorrectable errors.
- `err_valid_o`  out  1  capture registers hold a valid uncorrectable transaction.
- `err_we_o`, `err_be_o`, `err_aid_o`  out  1 / `DataWidth/8` / `IdWidth`  captured fields.
- `fault_o`  out  1  FSM is in FAULT.
- `irq_o`  out  1  registered interrupt level.

## Operation
- **Accepted transaction (hs):** `req_i & gnt_o`. Errors are evaluated only on hs; `relerr_i` is ignored otherwise.
- **Classification:**
  - `relerr_i[1]` set: the transaction is uncorrectable, whatever bit0 is.
  - `relerr_i == 2'b01`: the transaction is correctable.
  - `2'b00`: no action.
- **Counters:** increment by 1 on a qualifying hs and saturate at 2^CntWidth-1, with no wrap.
- **Capture:** on an uncorrectable hs while `err_valid_o == 0`, latch `we_i`/`be_i`/`aid_i` and set `err_valid_o`. Later uncorrectable errors increment the counter but do not overwrite the capture.
- **FSM states:** OK, FAULT.
  - OK: `req_o = req_i`, `gnt_o = gnt_i`, both combinational pass-through. An uncorrectable hs with `BlockOnUncorr == 1` moves to FAULT. The offending transaction itself has already been forwarded.
  - FAULT: `req_o = 0`, `gnt_o = 0`, `fault_o = 1`. No hs can occur. Leaves only via `clear_i` (to OK) or reset.
  - With `BlockOnUncorr == 0` the FSM never leaves OK.
- **clear_i:** in the next state, counters = 0, `err_valid_o = 0`, capture fields = 0, state = OK, `irq_o = 0`. If an event occurs in the same cycle as `clear_i`, the clear wins and the event is discarded (not counted, not captured).
- **irq_o next value:** `err_valid_o_next | (corr_cnt_o_next >= CorrThreshold)`.
- **Reset:** every register is 0 and state = OK, so all counters, `err_*`, `fault_o` and `irq_o` read 0. `req_o`/`gnt_o` follow their inputs from the first cycle after reset. A reset mid-FAULT returns to OK.

## Timing
- `req_o`/`gnt_o`: zero latency from `req_i`/`gnt_i`/state; purely combinational.
- Counters, capture, `err_valid_o`, `fault_o`, `irq_o`: registered. They update on the edge that ends the hs cycle and are visible 1 cycle after hs.
- The fence takes effect in the cycle after the uncorrectable hs. Exactly one erroneous transaction passes downstream.
- `clear_i` takes effect at the next edge. Grant pass-through resumes in the cycle after `clear_i`.
- There is no path from `relerr_i` to `req_o`/`gnt_o`.

## Test plan
- **Correctable error, threshold 1:** hs with `relerr_i=01`, `aid_i=3` -> next cycle `corr_cnt_o=1`, `irq_o=1`, `err_valid_o=0`, `fault_o=0`; traffic keeps flowing.
- **Uncorrectable error then fence:** hs with `relerr_i=11`, `aid_i=5`, `we_i=1`, `be_i=4'hF` -> next cycle `uncorr_cnt_o=1`, `corr_cnt_o=0`, `err_aid_o=5`, `err_we_o=1`, `err_be_o=F`, `fault_o=1`. With `req_i=1`, `gnt_i=1` held, `req_o=0` and `gnt_o=0`.
- **Capture priority and clear:** after the fence case, assert `clear_i`. Resume, then send uncorrectable hs with `aid_i=7` and `aid_i=9` (`BlockOnUncorr=0`) -> `err_aid_o=7`, `uncorr_cnt_o=2`.
- **Saturation:** `CntWidth=2`, 5 correctable hs -> `corr_cnt_o` reads 1,2,3,3,3.
- **Clear collides with event:** `clear_i=1` in the same cycle as a `relerr_i=10` hs -> next cycle counters = 0, `err_valid_o=0`, `fault_o=0`.
- **Reset:** reset during FAULT and during errors asserted without hs -> all outputs 0. An error on a cycle with `req_i=1`, `gnt_i=0` leaves the counters unchanged.
